// File: rtl/sirene_fabrica.sv
// Factory night/production siren: keeps a simulated week clock and raises a
// blinking alarm when every machine stays stopped under the alarm condition.
module sirene_fabrica #(
  parameter int NMAQ       = 4,
  parameter int TICKS_HORA = 8,
  parameter int HORA_FIM   = 18,
  parameter int NCONFIRMA  = 3,
  parameter int PISCA      = 2
) (
  input  logic            clk_2,
  input  logic            reset_n,
  input  logic [NMAQ-1:0] paradas_i,
  input  logic            producao,
  input  logic            ack,
  output logic [4:0]      hora,
  output logic [2:0]      dia,
  output logic            sirene,
  output logic [1:0]      estado
);

  localparam int TW = (TICKS_HORA > 1) ? $clog2(TICKS_HORA) : 1;
  localparam int CW = $clog2(NCONFIRMA);
  localparam int BW = $clog2(2 * PISCA);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CONFIRMA = 2'd1;
  localparam logic [1:0] ALARME   = 2'd2;
  localparam logic [1:0] SILENCIO = 2'd3;

  localparam logic [TW-1:0] TICK_MAX  = TW'(TICKS_HORA - 1);
  localparam logic [CW-1:0] CONF_LAST = CW'(NCONFIRMA - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(2 * PISCA - 1);
  localparam logic [BW-1:0] BLINK_ON  = BW'(PISCA);
  localparam logic [4:0]    FIM       = 5'(HORA_FIM);

  logic [TW-1:0] tick;
  logic [CW-1:0] conf;
  logic [BW-1:0] blink;
  logic [1:0]    state;
  logic          hour_wrap;
  logic          day_wrap;
  logic          cond;

  assign hour_wrap = (tick == TICK_MAX);
  assign day_wrap  = hour_wrap && (hora == 5'd23);

  assign cond = (&paradas_i) &
                ((hora >= FIM) | ((dia == 3'd4) & producao));

  assign estado = state;
  assign sirene = (state == ALARME) && (blink < BLINK_ON);

  // Wall clock runs regardless of alarm activity
  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      tick <= '0;
      hora <= '0;
      dia  <= '0;
    end else if (hour_wrap) begin
      tick <= '0;
      if (hora == 5'd23) begin
        hora <= '0;
        dia  <= (dia == 3'd6) ? 3'd0 : dia + 3'd1;
      end else begin
        hora <= hora + 5'd1;
      end
    end else begin
      tick <= tick + TW'(1);
    end
  end

  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      state <= IDLE;
      conf  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cond) begin
            state <= CONFIRMA;
            conf  <= CW'(1);
          end
        end
        CONFIRMA: begin
          if (!cond) begin
            state <= IDLE;
          end else if (conf == CONF_LAST) begin
            state <= ALARME;
          end else begin
            conf <= conf + CW'(1);
          end
        end
        ALARME: begin
          if (!cond)     state <= IDLE;
          else if (ack)  state <= SILENCIO;
        end
        SILENCIO: begin
          if (!cond) begin
            state <= IDLE;
          end else if (day_wrap) begin
            state <= CONFIRMA;
            conf  <= CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ALARME is only entered from CONFIRMA, so blink is zero on entry
  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      blink <= '0;
    end else if (state == ALARME) begin
      blink <= (blink == BLINK_MAX) ? '0 : blink + BW'(1);
    end else begin
      blink <= '0;
    end
  end

endmodule

// File: tb/tb_sirene_fabrica.sv
// Directed bench for sirene_fabrica: vector table at night hours plus
// hand sequences for the calendar, production day and silence-until-dawn.
module tb_sirene_fabrica;

  logic       clk_2 = 1'b0;
  logic       reset_n;
  logic [3:0] paradas_i;
  logic       producao;
  logic       ack;
  logic [4:0] hora;
  logic [2:0] dia;
  logic       sirene;
  logic [1:0] estado;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [3:0] par;
    logic       prod;
    logic       ak;
    logic [1:0] est;
    logic       sir;
  } vec_t;

  vec_t tab[$];

  sirene_fabrica dut (
    .clk_2     (clk_2),
    .reset_n   (reset_n),
    .paradas_i (paradas_i),
    .producao  (producao),
    .ack       (ack),
    .hora      (hora),
    .dia       (dia),
    .sirene    (sirene),
    .estado    (estado)
  );

  always #5 clk_2 = ~clk_2;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_2);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] p, input logic pr,
                     input logic a, input logic [1:0] e, input logic s);
    vec_t v;
    v.rst = r; v.par = p; v.prod = pr; v.ak = a; v.est = e; v.sir = s;
    tab.push_back(v);
  endtask

  initial begin
    // full alarm with blink, ack to silence, ack ignored in SILENCIO
    add(1, 4'hF, 0, 0, 2'd1, 0);
    add(1, 4'hF, 0, 0, 2'd1, 0);
    add(1, 4'hF, 0, 0, 2'd2, 1);
    add(1, 4'hF, 0, 0, 2'd2, 1);
    add(1, 4'hF, 0, 0, 2'd2, 0);
    add(1, 4'hF, 0, 0, 2'd2, 0);
    add(1, 4'hF, 0, 0, 2'd2, 1);
    add(1, 4'hF, 0, 1, 2'd3, 0);
    add(1, 4'hF, 0, 0, 2'd3, 0);
    add(1, 4'hF, 0, 1, 2'd3, 0);
    add(1, 4'h7, 0, 0, 2'd0, 0);
    // aborted confirmation
    add(1, 4'hF, 0, 0, 2'd1, 0);
    add(1, 4'hF, 0, 0, 2'd1, 0);
    add(1, 4'h7, 0, 0, 2'd0, 0);
    // ack ignored outside ALARME; loss of cond beats ack
    add(1, 4'hF, 0, 1, 2'd1, 0);
    add(1, 4'hF, 0, 0, 2'd1, 0);
    add(1, 4'hF, 0, 0, 2'd2, 1);
    add(1, 4'h0, 0, 1, 2'd0, 0);
    // reset in the middle of ALARME
    add(1, 4'hF, 0, 0, 2'd1, 0);
    add(1, 4'hF, 0, 0, 2'd1, 0);
    add(1, 4'hF, 0, 0, 2'd2, 1);
    add(0, 4'hF, 0, 0, 2'd0, 0);
    add(1, 4'hF, 0, 0, 2'd0, 0);

    reset_n = 0; paradas_i = 4'h0; producao = 0; ack = 0;
    step(1);
    check("rst_hora", hora, 0);
    check("rst_dia", dia, 0);
    check("rst_estado", estado, 0);
    check("rst_sirene", sirene, 0);

    reset_n = 1;
    step(144);
    check("h18_hora", hora, 18);
    check("h18_dia", dia, 0);

    for (int i = 0; i < tab.size(); i++) begin
      reset_n = tab[i].rst; paradas_i = tab[i].par;
      producao = tab[i].prod; ack = tab[i].ak;
      step(1);
      check($sformatf("vec%0d_estado", i), estado, tab[i].est);
      check($sformatf("vec%0d_sirene", i), sirene, tab[i].sir);
      if (tab[i].rst == 1'b0) begin
        check("midrst_hora", hora, 0);
        check("midrst_dia", dia, 0);
      end
    end

    // calendar from a fresh reset
    reset_n = 0; paradas_i = 4'h0; ack = 0; producao = 0;
    step(1);
    reset_n = 1;
    step(144);
    check("cal_h18", hora, 18);
    check("cal_d0", dia, 0);
    step(48);
    check("cal_h0", hora, 0);
    check("cal_d1", dia, 1);

    // thursday (dia 3) production met: no alarm
    step(2 * 192 + 80);
    check("thu_hora", hora, 10);
    check("thu_dia", dia, 3);
    paradas_i = 4'hF; producao = 1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check($sformatf("thu_est%0d", i), estado, 0);
    end
    paradas_i = 4'h0; producao = 0;
    step(189);
    check("fri_hora", hora, 10);
    check("fri_dia", dia, 4);

    // friday (dia 4) production met: alarm in daytime
    paradas_i = 4'hF; producao = 1;
    step(1); check("fri_est0", estado, 1);
    step(1); check("fri_est1", estado, 1);
    step(1); check("fri_est2", estado, 2);
    check("fri_sir", sirene, 1);
    producao = 0;
    step(1); check("fri_drop", estado, 0);

    // silenced at 23h re-arms at midnight
    paradas_i = 4'h0;
    step(100);
    check("sil_hora", hora, 23);
    paradas_i = 4'hF;
    step(3); check("sil_alarm", estado, 2);
    ack = 1;
    step(1); check("sil_enter", estado, 3);
    check("sil_sir", sirene, 0);
    ack = 0;
    step(3); check("sil_hold", estado, 3);
    step(1); check("sil_rearm", estado, 1);
    check("sil_h0", hora, 0);
    check("sil_d5", dia, 5);
    step(1); check("sil_idle", estado, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sirene_fabrica.md
SIRENE_FABRICA -- requirements
Module: sirene_fabrica

Interface
REQ-001 The module SHALL accept parameter NMAQ, default 4, giving the number of monitored machines (1..32).
REQ-002 The module SHALL accept parameter TICKS_HORA, default 8, giving the clock cycles per simulated hour (>=1).
REQ-003 The module SHALL accept parameter HORA_FIM, default 18, giving the hour (0..23) from which "noite" holds.
REQ-004 The module SHALL accept parameter NCONFIRMA, default 3, giving the consecutive qualifying cycles before the alarm fires (>=2).
REQ-005 The module SHALL accept parameter PISCA, default 2, giving the siren blink half-period in cycles (>=1).
REQ-006 The module SHALL have port clk_2, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The module SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-008 The module SHALL have port paradas_i, input, NMAQ bits: bit i = 1 means machine i is stopped.
REQ-009 The module SHALL have port producao, input, 1 bit: the day's production target has been met.
REQ-010 The module SHALL have port ack, input, 1 bit: operator silences the siren.
REQ-011 The module SHALL have port hora, output, 5 bits: current hour, 0..23.
REQ-012 The module SHALL have port dia, output, 3 bits: weekday, 0=segunda .. 4=sexta .. 6=domingo.
REQ-013 The module SHALL have port sirene, output, 1 bit: the blinking siren drive.
REQ-014 The module SHALL have port estado, output, 2 bits: FSM state code.

Function
REQ-015 Clock: tick counter SHALL count 0..TICKS_HORA-1; on wrap, hora SHALL increment; 23->0 SHALL increment dia; dia 6->0.
REQ-016 Alarm condition SHALL be cond = (&paradas_i) & ((hora >= HORA_FIM) | (dia == 4 & producao)), evaluated combinationally from the current registers and inputs.
REQ-017 FSM states SHALL be IDLE=0, CONFIRMA=1, ALARME=2, SILENCIO=3, with estado equal to the state code.
REQ-018 In IDLE: cond -> CONFIRMA with confirm count=1; otherwise stay.
REQ-019 In CONFIRMA: !cond -> IDLE; cond with count==NCONFIRMA-1 -> ALARME; else count+1 (ALARME is reached on the NCONFIRMA-th consecutive edge with cond=1).
REQ-020 In ALARME: !cond -> IDLE (takes priority over ack); ack & cond -> SILENCIO; else stay.
REQ-021 In SILENCIO: !cond -> IDLE; cond at the hour wrap 23->0 (new day) -> CONFIRMA with count=1; else stay.
REQ-022 ack SHALL be ignored in every state except ALARME.
REQ-023 Blink: counter SHALL clear on every entry to ALARME and count 0..2*PISCA-1 cyclically while in ALARME.
REQ-024 sirene SHALL be 1 iff state==ALARME and blink counter < PISCA, i.e. high on the first cycle in ALARME and never high outside it.
REQ-025 Time keeping SHALL run independently of FSM state and inputs.

Reset
REQ-026 With reset_n=0 at an edge: tick=0, hora=0, dia=0, state=IDLE, confirm and blink counters=0; hence sirene=0, estado=0.
REQ-027 Reset SHALL take priority over all other activity, including mid-ALARME; the first non-reset edge SHALL evaluate from IDLE.

Verification
REQ-028 Reset, then 18*TICKS_HORA edges (144 with defaults) -> hora=18, dia=0; a further 6*TICKS_HORA edges -> hora=0, dia=1.
REQ-029 hora=18, paradas_i=4'hF held -> estado 0->1->1->2 over 3 edges; sirene pattern 1,1,0,0,1,1...
REQ-030 hora=18, paradas_i=4'hF for 2 edges, then 4'h7 -> estado returns to 0 and sirene never rises.
REQ-031 dia=4, hora=10, producao=1, paradas_i=4'hF -> ALARME after 3 edges; same with dia=3 -> stays IDLE.
REQ-032 In ALARME, ack=1 -> SILENCIO with sirene=0; ack=1 with paradas_i=4'h0 in the same cycle -> IDLE.
REQ-033 reset_n=0 for one edge while in ALARME -> estado=0, sirene=0, hora=0, dia=0 on the next cycle.
